// File: rtl/sd_bd_fetch_if.sv
// Handshake bundle between the descriptor fetch engine, the sd_bd ring and the SD data master.
// The master modport is the fetch engine's view; slave is the ring/data-master side.
interface sd_bd_fetch_if #(
  parameter int MEM_W        = 16,
  parameter int BD_W         = 8,
  parameter int WORDS_PER_BD = 4
);
  localparam int F = MEM_W * WORDS_PER_BD / 2;

  logic [BD_W-1:0]  free_bd;
  logic             re_s;
  logic             ack_o_s;
  logic [MEM_W-1:0] dat_out_s;
  logic             a_cmp;
  logic             desc_valid;
  logic             desc_ready;
  logic [F-1:0]     desc_sys_addr;
  logic [F-1:0]     desc_card_addr;
  logic             xfer_done;

  modport master (
    output re_s, a_cmp, desc_valid, desc_sys_addr, desc_card_addr,
    input  free_bd, ack_o_s, dat_out_s, desc_ready, xfer_done
  );

  modport slave (
    input  re_s, a_cmp, desc_valid, desc_sys_addr, desc_card_addr,
    output free_bd, ack_o_s, dat_out_s, desc_ready, xfer_done
  );
endinterface

// File: rtl/sd_bd_fetch.sv
// Descriptor fetch engine: pops one descriptor from sd_bd word by word, hands it to the
// data master, waits for the transfer and retires the ring entry with a one-cycle a_cmp.
module sd_bd_fetch #(
  parameter int MEM_W        = 16,
  parameter int BD_W         = 8,
  parameter int BD_SIZE      = 8,
  parameter int WORDS_PER_BD = 4,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               rst,
  sd_bd_fetch_if.master      bus,
  input  logic               en,
  input  logic               err_clr,
  output logic               busy,
  output logic               fetch_err,
  output logic [15:0]        bd_cnt
);
  localparam int F     = MEM_W * WORDS_PER_BD / 2;
  localparam int IDX_W = (WORDS_PER_BD > 2) ? $clog2(WORDS_PER_BD) : 1;
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BD - 1);
  localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(WORDS_PER_BD / 2);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [BD_W-1:0]  RING_SZ  = BD_W'(BD_SIZE);

  typedef enum logic [2:0] {IDLE, REQ, GAP, PRESENT, BUSY, CMP, SETTLE} state_t;

  state_t           state;
  logic [IDX_W-1:0] word_idx;
  logic [TO_W-1:0]  to_cnt;
  logic             re_s_q;
  logic             a_cmp_q;
  logic             desc_valid_q;
  logic [F-1:0]     sys_addr_q;
  logic [F-1:0]     card_addr_q;

  // Anything above the ring depth is as good as empty, so only strictly-less starts a fetch.
  logic         ring_has_bd;
  logic [F-1:0] word_top;
  assign ring_has_bd = bus.free_bd < RING_SZ;
  // Words shift in from the top, so after a half's worth of words word 0 sits in the LSBs.
  assign word_top    = F'(bus.dat_out_s) << (F - MEM_W);

  assign bus.re_s           = re_s_q;
  assign bus.a_cmp          = a_cmp_q;
  assign bus.desc_valid     = desc_valid_q;
  assign bus.desc_sys_addr  = sys_addr_q;
  assign bus.desc_card_addr = card_addr_q;

  // NOTE: all state uses non-blocking assignments; where two assignments to the same
  // register fire in one cycle the later one in this block takes effect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      word_idx     <= '0;
      to_cnt       <= '0;
      re_s_q       <= 1'b0;
      a_cmp_q      <= 1'b0;
      desc_valid_q <= 1'b0;
      busy         <= 1'b0;
      fetch_err    <= 1'b0;
      bd_cnt       <= '0;
      sys_addr_q   <= '0;
      card_addr_q  <= '0;
    end else begin
      if (err_clr) fetch_err <= 1'b0;

      case (state)
        IDLE: begin
          if (en && ring_has_bd && !fetch_err) begin
            state    <= REQ;
            re_s_q   <= 1'b1;
            busy     <= 1'b1;
            word_idx <= '0;
            to_cnt   <= '0;
          end
        end
        REQ: begin
          if (bus.ack_o_s) begin
            re_s_q <= 1'b0;
            to_cnt <= '0;
            if (word_idx < HALF_IDX) sys_addr_q  <= (sys_addr_q  >> MEM_W) | word_top;
            else                     card_addr_q <= (card_addr_q >> MEM_W) | word_top;
            if (word_idx == LAST_IDX) begin
              state        <= PRESENT;
              desc_valid_q <= 1'b1;
            end else begin
              state    <= GAP;
              word_idx <= word_idx + IDX_W'(1);
            end
          end else if (to_cnt == TO_LAST) begin
            // Abandon the descriptor; the entry stays in the ring because no a_cmp is sent.
            re_s_q    <= 1'b0;
            fetch_err <= 1'b1;
            busy      <= 1'b0;
            to_cnt    <= '0;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        GAP: begin
          state  <= REQ;
          re_s_q <= 1'b1;
        end
        PRESENT: begin
          if (bus.desc_ready) begin
            desc_valid_q <= 1'b0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (bus.xfer_done) begin
            a_cmp_q <= 1'b1;
            bd_cnt  <= bd_cnt + 16'd1;
            state   <= CMP;
          end
        end
        CMP: begin
          a_cmp_q <= 1'b0;
          state   <= SETTLE;
        end
        SETTLE: begin
          // Gives sd_bd a cycle to publish the updated free_bd before IDLE samples it.
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sd_bd_fetch.md
Name: sd_bd_fetch

Overview:
Descriptor fetch engine placed directly downstream of the SD buffer-descriptor ring (sd_bd). It watches the ring's free-entry count and pops one descriptor at a time over the re_s/ack_o_s read handshake, assembling WORDS_PER_BD memory words into a system address and a card address. It offers the descriptor to the SD data master with a valid/ready handshake, waits for transfer completion, then pulses a_cmp so sd_bd can retire the entry.

Parameters:
MEM_W, 16, width of dat_out_s words (matches RAM_MEM_WIDTH)
BD_W, 8, width of free_bd (matches BD_WIDTH)
BD_SIZE, 8, ring depth; free_bd == BD_SIZE means the ring is empty
WORDS_PER_BD, 4, memory words per descriptor (even, >= 2)
ACK_TIMEOUT, 255, maximum cycles re_s may wait for ack_o_s

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
en  in  1  fetch enable; gates only the start of a new fetch
free_bd  in  BD_W  free ring entries reported by sd_bd
ack_o_s  in  1  sd_bd read acknowledge; dat_out_s is valid in the same cycle
dat_out_s  in  MEM_W  descriptor word from sd_bd
re_s  out  1  read request to sd_bd
a_cmp  out  1  one-cycle completion pulse to sd_bd
desc_valid  out  1  descriptor available to the data master
desc_ready  in  1  data master accepts the descriptor
desc_sys_addr  out  F  system address, F = MEM_W*WORDS_PER_BD/2
desc_card_addr  out  F  card address
xfer_done  in  1  data master transfer complete, single-cycle pulse
busy  out  1  high in any state other than IDLE
fetch_err  out  1  sticky ack-timeout flag
err_clr  in  1  clears fetch_err
bd_cnt  out  16  completed-descriptor counter, wraps modulo 2^16

Behaviour:
- Reset (rst low, asynchronous): state returns to IDLE. re_s, a_cmp, desc_valid, busy, fetch_err, bd_cnt, both address registers, the word index and the timeout counter all clear to 0.
- States: IDLE, REQ, GAP, PRESENT, BUSY, CMP, SETTLE.
- IDLE -> REQ when en=1, free_bd != BD_SIZE and fetch_err=0. The word index resets to 0 on this transition.
- REQ: re_s=1, held until ack_o_s is sampled high.
  - On ack, word i is captured. Words 0..W/2-1 fill desc_sys_addr least-significant word first; words W/2..W-1 fill desc_card_addr the same way.
  - After capture, the state goes to GAP, or to PRESENT if it was the last word.
  - re_s is 0 in the cycle after any ack, so every word uses its own request.
- GAP: re_s=0 for one cycle, then back to REQ.
- Timeout:
  - The counter increments each REQ cycle without ack and clears on ack.
  - When it reaches ACK_TIMEOUT, re_s drops, fetch_err is set and the state returns to IDLE without issuing a_cmp.
  - An ack in the same cycle as the timeout wins and no error is raised.
- PRESENT: desc_valid=1 with both addresses stable until desc_ready is sampled high, then BUSY. desc_valid drops in the cycle after acceptance.
- BUSY: waits for xfer_done, then CMP. xfer_done is ignored in every other state, including one that coincides with desc_ready in PRESENT.
- CMP: a_cmp=1 for exactly one cycle and bd_cnt increments, then SETTLE.
- SETTLE: one idle cycle so that sd_bd's updated free_bd is visible, then IDLE. Back-to-back descriptors are therefore separated by at least two cycles after a_cmp.
- en only gates IDLE->REQ. Dropping en mid-descriptor does not stop it; the descriptor runs to CMP.
- err_clr clears fetch_err in any state. When err_clr and the timeout occur in the same cycle, set wins.
- free_bd is sampled only in IDLE. free_bd > BD_SIZE is treated as empty.
- Outputs are registered; a_cmp and re_s are glitch-free register outputs.

Test Plan:
1. Single fetch: free_bd 8->7, ack_o_s one cycle after each re_s, words 0x1111,0x2222,0x3333,0x4444 -> desc_sys_addr=0x22221111, desc_card_addr=0x44443333; desc_ready then xfer_done -> one a_cmp pulse; bd_cnt=1.
2. Back-to-back: free_bd=6, with the bd model raising free_bd after each a_cmp -> two descriptors fetched, re_s low for at least 2 cycles after each a_cmp, bd_cnt=2, then IDLE with busy=0.
3. Delayed ack: ack_o_s arrives 10 cycles after re_s -> re_s held high for all 10 cycles, data captured only on the ack cycle, re_s low the following cycle.
4. Timeout: ack_o_s never asserted, ACK_TIMEOUT=255 -> re_s drops after 255 cycles, fetch_err=1, no a_cmp, no new fetch despite free_bd=7; err_clr -> fetch_err=0 and the fetch restarts.
5. Enable and ignored events: en=0 with free_bd=7 -> re_s stays 0; en dropped while in BUSY -> descriptor still completes with a_cmp; xfer_done pulsed in IDLE -> no effect.
6. Reset mid-operation: rst low during PRESENT -> desc_valid, re_s, busy and bd_cnt are 0 immediately (asynchronously); after release with en=1 and free_bd=7 -> fresh fetch begins at word 0.
